mem_port_arbiter: RTL

//  Parametrised successor to the single-master memory mux: arbitrates N_CH requesters onto the

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/mem_port_arbiter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the memory port arbiter: transfer lengths, FSM states, length decode.
package mem_arb_pkg;

  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_4B = 2'd2;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    XFER      = 2'd1,
    READ_TAIL = 2'd2,
    DONE      = 2'd3
  } state_t;

  // Reserved length code 3 is served as a 4-byte transfer.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_1B:  return 3'd1;
      LEN_2B:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Request vector to one-hot grant. Round-robin when ARB_ROUND_ROBIN_EN is defined,
// otherwise fixed priority with channel 0 highest.
module rr_arbiter #(
  parameter int unsigned N_CH = 3
) (
`ifdef ARB_ROUND_ROBIN_EN
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
`endif
  input  logic [N_CH-1:0]         req,
  output logic [N_CH-1:0]         grant_c,
  output logic [$clog2(N_CH)-1:0] idx_c
);

  localparam int unsigned CH_W = $clog2(N_CH);

`ifdef ARB_ROUND_ROBIN_EN
  logic [CH_W-1:0] ptr;

  // ptr holds the last granted channel; search starts one past it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ptr <= '0;
    else if (advance) ptr <= idx_c;
  end

  // Walk from farthest to nearest offset so the nearest requester wins.
  always_comb begin
    int unsigned j;
    grant_c = '0;
    idx_c   = '0;
    j       = 0;
    for (int unsigned i = N_CH; i >= 1; i--) begin
      j = 32'(ptr) + i;
      if (j >= N_CH) j = j - N_CH;
      if (req[j]) begin
        grant_c    = '0;
        grant_c[j] = 1'b1;
        idx_c      = CH_W'(j);
      end
    end
  end
`else
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_c    = '0;
        grant_c[i] = 1'b1;
        idx_c      = CH_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates N_CH requesters onto a byte-wide memory bus with 1-cycle read latency.
// Arbitration policy selected by ARB_ROUND_ROBIN_EN (round-robin) or fixed priority when undefined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N_CH       = 3,
  parameter int unsigned ADDR_W     = 32,
  parameter logic [1:0]  IO_HI_BITS = 2'b11
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic [N_CH-1:0]          req_valid,
  input  logic [N_CH-1:0]          req_wr,
  input  logic [2*N_CH-1:0]        req_len,
  input  logic [ADDR_W*N_CH-1:0]   req_addr,
  input  logic [32*N_CH-1:0]       req_wdata,
  output logic [N_CH-1:0]          done,
  output logic [31:0]              rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic                     mem_wr,
  output logic [7:0]               mem_dout,
  input  logic [7:0]               mem_din,
  output logic                     io_sel
);

  localparam int unsigned CH_W = $clog2(N_CH);

  state_t            state, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic              wr_q, wr_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        k_q, k_d;
  logic [1:0]        prev_k, last_k;
  logic [31:0]       rbuf_q, rbuf_d;
  logic [N_CH-1:0]   done_q, done_d;
  logic [31:0]       rdata_d;
  logic              busy_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic              mem_wr_q, mem_wr_d;
  logic [7:0]        mem_dout_d;

  logic [N_CH-1:0]   grant_c;
  logic [CH_W-1:0]   idx_c;
  logic              take_c;

  assign take_c = rdy_in && (state == IDLE) && (|grant_c);

  rr_arbiter #(.N_CH(N_CH)) u_arb (
`ifdef ARB_ROUND_ROBIN_EN
    .clk     (clk_in),
    .rst     (rst_in),
    .advance (take_c),
`endif
    .req     (req_valid),
    .grant_c (grant_c),
    .idx_c   (idx_c)
  );

  // Pause must silence the bus and the done pulse in the same cycle.
  assign done   = done_q & {N_CH{rdy_in}};
  assign mem_wr = mem_wr_q & rdy_in;
  assign io_sel = (mem_addr[17:16] == IO_HI_BITS);

  assign prev_k = k_q - 2'd1;
  assign last_k = 2'(nbytes_q - 3'd1);

  always_comb begin
    state_d    = state;
    gnt_d      = gnt_q;
    wr_d       = wr_q;
    nbytes_d   = nbytes_q;
    wdata_d    = wdata_q;
    k_d        = k_q;
    rbuf_d     = rbuf_q;
    done_d     = '0;
    rdata_d    = rdata;
    busy_d     = busy;
    mem_addr_d = mem_addr;
    mem_wr_d   = 1'b0;
    mem_dout_d = mem_dout;
    case (state)
      IDLE: begin
        if (take_c) begin
          state_d    = XFER;
          gnt_d      = idx_c;
          wr_d       = req_wr[idx_c];
          nbytes_d   = len_bytes(req_len[2*idx_c +: 2]);
          wdata_d    = req_wdata[32*idx_c +: 32];
          k_d        = '0;
          rbuf_d     = '0;
          busy_d     = 1'b1;
          mem_addr_d = req_addr[ADDR_W*idx_c +: ADDR_W];
          mem_wr_d   = req_wr[idx_c];
          mem_dout_d = req_wdata[32*idx_c +: 8];
        end
      end
      XFER: begin
        // Byte issued last cycle is on mem_din now.
        if (!wr_q && (k_q != 2'd0)) rbuf_d[{prev_k, 3'b000} +: 8] = mem_din;
        if (k_q == last_k) begin
          if (wr_q) begin
            state_d        = DONE;
            done_d[gnt_q]  = 1'b1;
            busy_d         = 1'b0;
          end else begin
            state_d = READ_TAIL;
          end
        end else begin
          k_d        = k_q + 2'd1;
          mem_addr_d = mem_addr + ADDR_W'(1);
          mem_wr_d   = wr_q;
          mem_dout_d = wdata_q[{k_d, 3'b000} +: 8];
        end
      end
      READ_TAIL: begin
        rbuf_d[{last_k, 3'b000} +: 8] = mem_din;
        rdata_d       = rbuf_d;
        done_d[gnt_q] = 1'b1;
        busy_d        = 1'b0;
        state_d       = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= IDLE;
      gnt_q    <= '0;
      wr_q     <= 1'b0;
      nbytes_q <= 3'd1;
      wdata_q  <= '0;
      k_q      <= '0;
      rbuf_q   <= '0;
      done_q   <= '0;
      rdata    <= '0;
      busy     <= 1'b0;
      mem_addr <= '0;
      mem_wr_q <= 1'b0;
      mem_dout <= '0;
    end else if (rdy_in) begin
      state    <= state_d;
      gnt_q    <= gnt_d;
      wr_q     <= wr_d;
      nbytes_q <= nbytes_d;
      wdata_q  <= wdata_d;
      k_q      <= k_d;
      rbuf_q   <= rbuf_d;
      done_q   <= done_d;
      rdata    <= rdata_d;
      busy     <= busy_d;
      mem_addr <= mem_addr_d;
      mem_wr_q <= mem_wr_d;
      mem_dout <= mem_dout_d;
    end
  end

endmodule
